// File: rtl/led_pattern_gen_pkg.sv
// Shared types for the LED pattern engine.
//   mode_e : pattern select encoding (matches the 2-bit mode input)
//   dir_e  : bounce direction
//   mode_init_lit : whether a freshly selected mode starts with Led = 1 (else 0)
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ModeCount  = 2'd0,
    ModeRotate = 2'd1,
    ModeBounce = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

  // ROTATE and BOUNCE need a single lit LED to be meaningful; COUNT and BLINK start dark.
  function automatic logic mode_init_lit(input mode_e m);
    return (m == ModeRotate) || (m == ModeBounce);
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// Programmable prescaler producing one pattern step every div_reg+1 cycles.
//   mclk  : clock, rising edge
//   rst   : synchronous active-high reset (cnt=0, div_reg=DEFAULT_DIV, tick=0)
//   clr   : restart the period (cnt=0, tick=0); beats load and hold
//   load  : load value into div_reg and restart the period; beats hold
//   value : new reload value
//   hold  : freeze cnt, force tick low
//   tick  : registered one-cycle pulse on each step
//   step  : combinational "a step happens at this edge" for same-cycle pattern update
module tick_divider
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned         DIV_W       = 24,
  parameter logic [DIV_W-1:0]    DEFAULT_DIV = DIV_W'(12_499_999)
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  input  logic             hold,
  output logic             tick,
  output logic             step
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_div);
  assign step   = !clr && !load && !hold && w_wrap;
  assign tick   = r_tick;

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_div  <= DEFAULT_DIV;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (load) begin
      r_div  <= value;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (hold) begin
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled steps drive one of COUNT / ROTATE / BOUNCE / BLINK.
//   mclk      : clock, rising edge
//   rst       : synchronous active-high reset
//   mode      : pattern select (0 COUNT, 1 ROTATE, 2 BOUNCE, 3 BLINK)
//   div_load  : one-cycle strobe loading div_value as the new reload value
//   div_value : reload value, step period = div_value+1 cycles
//   pause     : freeze prescaler and pattern
//   Led       : registered LED drive, bit0 = rightmost
//   tick      : registered one-cycle pulse on each step, aligned with the new Led value
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned      LED_W       = 4,
  parameter int unsigned      DIV_W       = 24,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(12_499_999)
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             pause,
  output logic [LED_W-1:0] Led,
  output logic             tick
);

  mode_e             r_mode;
  dir_e              r_dir;
  logic [LED_W-1:0]  r_led;

  mode_e             w_mode;
  logic              w_mode_chg;
  logic              w_step;
  logic              w_onehot;
  logic [LED_W-1:0]  w_led_step;
  dir_e              w_dir_step;

  assign w_mode     = mode_e'(mode);
  assign w_mode_chg = (w_mode != r_mode);
  assign Led        = r_led;

  tick_divider #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_tick_divider (
    .mclk  (mclk),
    .rst   (rst),
    .clr   (w_mode_chg),
    .load  (div_load),
    .value (div_value),
    .hold  (pause),
    .tick  (tick),
    .step  (w_step)
  );

  assign w_onehot = (r_led != '0) && ((r_led & (r_led - LED_W'(1))) == '0);

  // Pattern value after one step from the current state.
  always_comb begin
    w_led_step = r_led;
    w_dir_step = r_dir;
    unique case (r_mode)
      ModeCount:  w_led_step = r_led + LED_W'(1);
      // Shift-or form also covers LED_W=1, where it reduces to a hold.
      ModeRotate: w_led_step = (r_led << 1) | (r_led >> (LED_W - 1));
      ModeBounce: begin
        if (LED_W == 1) begin
          w_led_step = LED_W'(1);
        end else if (!w_onehot) begin
          // Recover from a corrupted pattern by restarting at the right end.
          w_led_step = LED_W'(1);
          w_dir_step = DirLeft;
        end else if (r_dir == DirLeft) begin
          w_led_step = r_led << 1;
          if (w_led_step[LED_W-1]) w_dir_step = DirRight;
        end else begin
          w_led_step = r_led >> 1;
          if (w_led_step[0]) w_dir_step = DirLeft;
        end
      end
      ModeBlink:  w_led_step = ~r_led;
      default:    w_led_step = r_led;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_mode <= ModeCount;
      r_dir  <= DirLeft;
      r_led  <= '0;
    end else if (w_mode_chg) begin
      r_mode <= w_mode;
      r_dir  <= DirLeft;
      r_led  <= mode_init_lit(w_mode) ? LED_W'(1) : '0;
    end else if (w_step) begin
      r_led  <= w_led_step;
      r_dir  <= w_dir_step;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios with literal expectations, then random
// stimulus, with a behavioural model compared against the outputs every cycle.
module tb_led_pattern_gen;

  localparam int unsigned LED_W = 4;
  localparam int unsigned DIV_W = 8;
  localparam int          NLED  = 1 << LED_W;
  localparam logic [DIV_W-1:0] DEF_DIV = 8'd2;

  logic             mclk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             pause = 1'b0;
  logic [LED_W-1:0] Led;
  logic             tick;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  led_pattern_gen #(
    .LED_W       (LED_W),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .mode      (mode),
    .div_load  (div_load),
    .div_value (div_value),
    .pause     (pause),
    .Led       (Led),
    .tick      (tick)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: LED value as an integer, bounce as a lit-position index.
  int m_led, m_cnt, m_div, m_mode, m_pos, m_tick;
  bit m_up;

  always @(posedge mclk) begin
    if (rst) begin
      m_led = 0; m_tick = 0; m_cnt = 0; m_div = int'(DEF_DIV); m_mode = 0;
      m_pos = 0; m_up = 1'b1;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_tick = 0; m_pos = 0; m_up = 1'b1;
      m_led  = (m_mode == 1 || m_mode == 2) ? 1 : 0;
    end else if (div_load) begin
      m_div = int'(div_value); m_cnt = 0; m_tick = 0;
    end else if (pause) begin
      m_tick = 0;
    end else if (m_cnt == m_div) begin
      m_cnt = 0; m_tick = 1;
      case (m_mode)
        0: m_led = (m_led + 1) % NLED;
        1: m_led = ((m_led * 2) % NLED) + m_led / (NLED / 2);
        2: begin
          m_pos = m_up ? m_pos + 1 : m_pos - 1;
          if (m_pos == LED_W - 1) m_up = 1'b0;
          if (m_pos == 0) m_up = 1'b1;
          m_led = 1 << m_pos;
        end
        default: m_led = (NLED - 1) - m_led;
      endcase
    end else begin
      m_cnt++; m_tick = 0;
    end
  end

  always @(negedge mclk) begin
    if (cmp_en) begin
      check("model_led", 32'(Led), 32'(m_led));
      check("model_tick", 32'(tick), 32'(m_tick));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      @(negedge mclk);
    end
  endtask

  int bounce_exp[8] = '{2, 4, 8, 4, 2, 1, 2, 4};

  initial begin
    // 1: reset for two cycles, first COUNT tick three cycles after release.
    @(negedge mclk);
    step(2);
    cmp_en = 1'b1;
    check("rst_led", 32'(Led), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    step(2);
    check("first_tick_early", 32'(tick), 32'd0);
    step(1);
    check("first_tick", 32'(tick), 32'd1);
    check("first_led", 32'(Led), 32'd1);

    // 2: COUNT through wrap.
    for (int k = 2; k <= 17; k++) begin
      step(2);
      check("count_gap_tick", 32'(tick), 32'd0);
      step(1);
      check("count_tick", 32'(tick), 32'd1);
      check("count_led", 32'(Led), 32'(k % 16));
    end

    // 3: BOUNCE every cycle.
    mode = 2'd2;
    step(1);
    check("bounce_init", 32'(Led), 32'd1);
    div_load = 1'b1; div_value = 8'd0;
    step(1);
    div_load = 1'b0;
    check("bounce_load_led", 32'(Led), 32'd1);
    check("bounce_load_tick", 32'(tick), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("bounce_seq", 32'(Led), 32'(bounce_exp[i]));
    end

    // 4: ROTATE wrap, then BLINK mid-period.
    mode = 2'd1;
    step(1);
    check("rot_init", 32'(Led), 32'd1);
    step(3);
    check("rot_8", 32'(Led), 32'd8);
    step(1);
    check("rot_wrap", 32'(Led), 32'd1);
    div_load = 1'b1; div_value = 8'd3;
    step(1);
    div_load = 1'b0;
    step(1);
    mode = 2'd3;
    step(1);
    check("blink_init", 32'(Led), 32'd0);
    check("blink_init_tick", 32'(tick), 32'd0);
    step(3);
    check("blink_early", 32'(tick), 32'd0);
    step(1);
    check("blink_on", 32'(Led), 32'd15);
    step(4);
    check("blink_off", 32'(Led), 32'd0);
    check("blink_off_tick", 32'(tick), 32'd1);

    // 5: pause mid-COUNT, then load under pause.
    mode = 2'd0;
    step(1);
    step(20);
    check("pause_pre", 32'(Led), 32'd5);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("pause_led", 32'(Led), 32'd5);
      check("pause_tick", 32'(tick), 32'd0);
    end
    pause = 1'b0;
    step(3);
    check("resume_hold", 32'(Led), 32'd5);
    step(1);
    check("resume_led", 32'(Led), 32'd6);
    pause = 1'b1; div_load = 1'b1; div_value = 8'd5;
    step(1);
    pause = 1'b0; div_load = 1'b0;
    step(5);
    check("load_pause_early", 32'(tick), 32'd0);
    step(1);
    check("load_pause_tick", 32'(tick), 32'd1);
    check("load_pause_led", 32'(Led), 32'd7);

    // 6: reset beats simultaneous load and mode change.
    rst = 1'b1; div_load = 1'b1; div_value = 8'd7; mode = 2'd2;
    step(1);
    check("rst_pri_led", 32'(Led), 32'd0);
    check("rst_pri_tick", 32'(tick), 32'd0);
    rst = 1'b0; div_load = 1'b0; mode = 2'd0;
    step(2);
    check("rst_pri_early", 32'(tick), 32'd0);
    step(1);
    check("rst_pri_tick2", 32'(tick), 32'd1);
    check("rst_pri_led2", 32'(Led), 32'd1);

    // Random phase, checked against the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      div_load = ($urandom_range(0, 39) == 0);
      div_value = 8'($urandom_range(0, 5));
      pause    = ($urandom_range(0, 4) == 0);
      step(1);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
